// File: rtl/iob_2p_assim_mem_reader_if.sv
// Valid/ready output stream of the asymmetric two-port memory reader.
// The master drives the word and its valid flag; the slave returns ready.
interface iob_2p_assim_mem_reader_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/iob_2p_assim_mem_reader.sv
// Streaming read-side controller: drains a contiguous run of words from the
// memory read port (one-cycle latency) into a 4-entry buffer feeding a stream.
module iob_2p_assim_mem_reader #(
  parameter int R_DATA_W = 8,
  parameter int R_ADDR_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [R_ADDR_W-1:0] start_addr,
  input  logic [R_ADDR_W:0]   len,
  output logic                busy,
  output logic                done,
  output logic                mem_r_en,
  output logic [R_ADDR_W-1:0] mem_r_addr,
  input  logic [R_DATA_W-1:0] mem_data,
  iob_2p_assim_mem_reader_if.master m
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_e;

  localparam logic [R_ADDR_W:0] LEN_ONE = (R_ADDR_W+1)'(1);

  state_e              state_q;
  logic [R_ADDR_W-1:0] addr_q;
  logic [R_ADDR_W:0]   issue_left_q;
  logic [R_ADDR_W:0]   pop_left_q;
  logic                busy_q;
  logic                done_q;
  logic                r_en_q;
  logic [R_ADDR_W-1:0] r_addr_q;
  logic                cap_q;
  logic [2:0]          occ_q;
  logic [2:0]          occ_d;
  logic [1:0]          out_q;
  logic [1:0]          out_d;
  logic [1:0]          wr_ptr_q;
  logic [1:0]          rd_ptr_q;
  logic [R_DATA_W-1:0] buf_mem [4];

  logic hs;
  logic start_issue;
  logic run_issue;
  logic issue;

  // Credit rule: buffered words plus reads in flight never exceed the buffer
  // depth, judged on registered counts only.
  always_comb begin
    hs          = (occ_q != 3'd0) && m.m_ready;
    start_issue = (state_q == ST_IDLE) && start && (len != '0);
    run_issue   = (state_q == ST_RUN) && (issue_left_q != '0) &&
                  (({1'b0, occ_q} + {2'b00, out_q}) < 4'd4);
    issue       = start_issue || run_issue;
    occ_d       = occ_q + 3'(cap_q) - 3'(hs);
    out_d       = out_q + 2'(issue) - 2'(cap_q);
  end

  // NOTE: every register below uses <= so all updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      r_en_q       <= 1'b0;
      r_addr_q     <= '0;
      cap_q        <= 1'b0;
      occ_q        <= '0;
      out_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      r_en_q <= issue;
      if (issue) begin
        r_addr_q <= start_issue ? start_addr : addr_q;
      end
      cap_q <= r_en_q;
      occ_q <= occ_d;
      out_q <= out_d;
      if (cap_q) begin
        wr_ptr_q <= wr_ptr_q + 2'd1;
      end
      if (hs) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      done_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pop_left_q <= len;
            if (len == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              // The first read goes out on the accepting edge itself.
              state_q      <= ST_RUN;
              busy_q       <= 1'b1;
              addr_q       <= start_addr + 1'b1;
              issue_left_q <= len - 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (run_issue) begin
            addr_q       <= addr_q + 1'b1;
            issue_left_q <= issue_left_q - 1'b1;
          end
          if (hs) begin
            pop_left_q <= pop_left_q - 1'b1;
            if (pop_left_q == LEN_ONE) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_FIN: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: buffer storage has no reset; m_data is gated by m_valid instead.
  always_ff @(posedge clk) begin
    if (cap_q) begin
      buf_mem[wr_ptr_q] <= mem_data;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_r_en   = r_en_q;
  assign mem_r_addr = r_addr_q;
  assign m.m_valid  = (occ_q != 3'd0);
  assign m.m_data   = (occ_q != 3'd0) ? buf_mem[rd_ptr_q] : '0;

  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    occ_q <= 3'd4);
  a_out_bound : assert property (@(posedge clk) disable iff (!rst_n)
    out_q <= 2'd2);
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(cap_q && (occ_q == 3'd4) && !hs));

endmodule

// File: tb/tb_iob_2p_assim_mem_reader.sv
// Scoreboard bench for the memory reader: stimulus pushes expected addresses
// and words, a negedge monitor pops and compares on every read and handshake.
module tb_iob_2p_assim_mem_reader;

  localparam int DW = 8;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy;
  logic          done;
  logic          mem_r_en;
  logic [AW-1:0] mem_r_addr;
  logic [DW-1:0] mem_data = '0;

  iob_2p_assim_mem_reader_if #(.DATA_W(DW)) s_if ();

  iob_2p_assim_mem_reader #(.R_DATA_W(DW), .R_ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_r_en   (mem_r_en),
    .mem_r_addr (mem_r_addr),
    .mem_data   (mem_data),
    .m          (s_if)
  );

  always #5 clk = ~clk;

  // Memory read port with one-cycle registered latency.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clk) if (mem_r_en) mem_data <= mem[mem_r_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];

  int start_cyc = 0;
  int mon_cyc, en_cnt, hs_cnt, first_en, last_en, first_hs, last_hs, done_cyc;
  int inflight, max_inflight;
  bit busy_seen, done_seen, prev_stall;
  logic [DW-1:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      mon_cyc = cyc - start_cyc;
      if (mem_r_en) begin
        en_cnt++;
        if (first_en < 0) first_en = mon_cyc;
        last_en = mon_cyc;
        inflight++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_read: addr=%0d, no read expected", mem_r_addr);
        end else begin
          check("rd_addr", 32'(mem_r_addr), 32'(exp_addr_q.pop_front()));
        end
      end
      if (inflight > max_inflight) max_inflight = inflight;
      if (busy) busy_seen = 1'b1;
      if (prev_stall) check("m_data_hold", 32'(s_if.m_data), 32'(prev_data));
      if (s_if.m_valid && s_if.m_ready) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = mon_cyc;
        last_hs = mon_cyc;
        inflight--;
        if (exp_data_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: data=0x%0h, no word expected", s_if.m_data);
        end else begin
          check("m_data", 32'(s_if.m_data), 32'(exp_data_q.pop_front()));
        end
      end
      prev_stall = s_if.m_valid && !s_if.m_ready;
      prev_data  = s_if.m_data;
      if (done) begin
        done_seen = 1'b1;
        done_cyc  = mon_cyc;
      end
    end
  end

  task automatic do_start(input int addr, input int n);
    logic [AW-1:0] a;
    start_addr = AW'(addr);
    len        = (AW+1)'(n);
    for (int i = 0; i < n; i++) begin
      a = AW'(addr + i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(DW'(a) + 8'h10);
    end
    en_cnt = 0; hs_cnt = 0; first_en = -1; last_en = -1;
    first_hs = -1; last_hs = -1; done_cyc = -1;
    inflight = 0; max_inflight = 0;
    busy_seen = 1'b0; done_seen = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc - 1;
    check("busy_cycle1", 32'(busy), 32'(n != 0));
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!done_seen && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done_seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
    check({name, "_sb_data_empty"}, 32'(exp_data_q.size()), 0);
    check({name, "_sb_addr_empty"}, 32'(exp_addr_q.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = DW'(i + 16);
    s_if.m_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_r_en", 32'(mem_r_en), 0);
    check("rst_r_addr", 32'(mem_r_addr), 0);
    check("rst_valid", 32'(s_if.m_valid), 0);
    check("rst_data", 32'(s_if.m_data), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic: words 0x15..0x18 in cycles 3..6, done in 7
    do_start(5, 4);
    wait_done("basic", 50);
    check("basic_first_en", 32'(first_en), 1);
    check("basic_last_en", 32'(last_en), 4);
    check("basic_en_cnt", 32'(en_cnt), 4);
    check("basic_first_hs", 32'(first_hs), 3);
    check("basic_last_hs", 32'(last_hs), 6);
    check("basic_done_cyc", 32'(done_cyc), 7);

    // Wrap: addresses 126,127,0,1
    do_start(126, 4);
    wait_done("wrap", 50);
    check("wrap_hs_cnt", 32'(hs_cnt), 4);
    check("wrap_done_cyc", 32'(done_cyc), 7);

    // Backpressure: ready low in cycles 0..12, high from 13
    s_if.m_ready = 1'b0;
    do_start(20, 10);
    repeat (11) @(posedge clk);
    #1;
    check("bp_reads_before_stall", 32'(en_cnt), 4);
    check("bp_r_en_stalled", 32'(mem_r_en), 0);
    check("bp_valid_stalled", 32'(s_if.m_valid), 1);
    check("bp_head_word", 32'(s_if.m_data), 32'h24);
    @(posedge clk);
    #1;
    s_if.m_ready = 1'b1;
    wait_done("bp", 100);
    check("bp_hs_cnt", 32'(hs_cnt), 10);
    check("bp_last_hs", 32'(last_hs), 22);
    check("bp_done_cyc", 32'(done_cyc), 23);
    check("bp_max_inflight", 32'(max_inflight), 4);

    // len = 0: done in cycle 1, no reads, never busy
    do_start(9, 0);
    wait_done("len0", 10);
    check("len0_done_cyc", 32'(done_cyc), 1);
    check("len0_en_cnt", 32'(en_cnt), 0);
    check("len0_hs_cnt", 32'(hs_cnt), 0);
    check("len0_busy_seen", 32'(busy_seen), 0);

    // Start pulse while busy is ignored
    do_start(40, 6);
    @(posedge clk);
    #1;
    start_addr = '0;
    len        = 8'd2;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("busy_start", 50);
    check("busy_start_en_cnt", 32'(en_cnt), 6);
    check("busy_start_last_hs", 32'(last_hs), 8);
    check("busy_start_done_cyc", 32'(done_cyc), 9);

    // Random ready, full memory
    do_start(0, 128);
    begin
      int n = 0;
      while (!done_seen && n < 3000) begin
        s_if.m_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        n++;
      end
    end
    s_if.m_ready = 1'b1;
    wait_done("rand", 10);
    check("rand_hs_cnt", 32'(hs_cnt), 128);
    check("rand_inflight_le4", 32'(max_inflight <= 4), 1);
    check("rand_done_after_hs", 32'(done_cyc), 32'(last_hs + 1));

    // Reset in cycle 5 of a len=20 transfer
    do_start(50, 20);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_r_en", 32'(mem_r_en), 0);
    check("mid_rst_r_addr", 32'(mem_r_addr), 0);
    check("mid_rst_valid", 32'(s_if.m_valid), 0);
    check("mid_rst_data", 32'(s_if.m_data), 0);
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(s_if.m_valid), 0);
    do_start(0, 2);
    wait_done("post_rst", 50);
    check("post_rst_hs_cnt", 32'(hs_cnt), 2);
    check("post_rst_en_cnt", 32'(en_cnt), 2);
    check("post_rst_done_cyc", 32'(done_cyc), 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
